// File: rtl/beta_dmem_bridge_if.sv
// Core-side and memory-side bus bundles for the Beta data-memory bridge.
// Core bundle: the core is master, the bridge is slave. Memory bundle: the bridge is master.
interface beta_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] Adr;
  logic [DATA_W-1:0] WD;
  logic              MOE;
  logic              MWR;
  logic [DATA_W-1:0] RD;
  logic              STALL;
  logic              MERR;

  modport master (output Adr, WD, MOE, MWR, input RD, STALL, MERR);
  modport slave  (input Adr, WD, MOE, MWR, output RD, STALL, MERR);
endinterface

interface beta_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-3:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport master (output m_req, m_we, m_addr, m_wdata, input m_ack, m_rdata);
  modport slave  (input m_req, m_we, m_addr, m_wdata, output m_ack, m_rdata);
endinterface

// File: rtl/beta_dmem_bridge.sv
// Bridges single-cycle Beta LD/ST requests onto a req/ack word memory, stalling the core
// until completion; flags misalignment, MOE&MWR and ack timeout on MERR.
//
// state   | meaning
// IDLE    | sample MOE/MWR/Adr/WD, issue or reject
// RD_WAIT | read issued, waiting for m_ack or timeout
// WR_WAIT | write issued, waiting for m_ack or timeout
// DONE    | STALL low one cycle so the core retires the LD/ST
module beta_dmem_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       RESET,
  beta_core_if.slave core,
  beta_mem_if.master mem
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [DATA_W-1:0] rd_q, rd_nx;
  logic              merr_q, merr_nx;
  logic              req_q, req_nx;
  logic              we_q, we_nx;
  logic [ADDR_W-3:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic              stall;
  logic              bad_req;

  assign bad_req = (core.Adr[1:0] != 2'b00) || (core.MOE && core.MWR);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= '0;
      merr_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rd_q    <= rd_nx;
      merr_q  <= merr_nx;
      req_q   <= req_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rd_nx    = rd_q;
    merr_nx  = 1'b0;
    req_nx   = req_q;
    we_nx    = we_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        stall = core.MOE | core.MWR;
        if (core.MOE || core.MWR) begin
          cnt_nx = '0;
          if (bad_req) begin
            merr_nx  = 1'b1;
            if (core.MOE) rd_nx = '0;
            state_nx = DONE;
          end else begin
            req_nx  = 1'b1;
            we_nx   = core.MWR;
            addr_nx = core.Adr[ADDR_W-1:2];
            if (core.MWR) begin
              wdata_nx = core.WD;
              state_nx = WR_WAIT;
            end else begin
              state_nx = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        stall = 1'b1;
        if (mem.m_ack) begin
          req_nx   = 1'b0;
          if (state == RD_WAIT) rd_nx = mem.m_rdata;
          state_nx = DONE;
        end else if (cnt == CNT_TC) begin
          // abort: the memory never answered within the allowed window
          req_nx   = 1'b0;
          merr_nx  = 1'b1;
          if (state == RD_WAIT) rd_nx = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign core.STALL  = stall & ~RESET;
  assign core.RD     = rd_q;
  assign core.MERR   = merr_q;
  assign mem.m_req   = req_q;
  assign mem.m_we    = we_q;
  assign mem.m_addr  = addr_q;
  assign mem.m_wdata = wdata_q;

endmodule

// File: tb/tb_beta_dmem_bridge.sv
// Randomized transaction bench for beta_dmem_bridge with a per-transaction cycle model
// and a word-memory reference; a negedge process compares every cycle.
module tb_beta_dmem_bridge;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  beta_core_if #(.DATA_W(32), .ADDR_W(32)) core ();
  beta_mem_if  #(.DATA_W(32), .ADDR_W(32)) mem ();

  beta_dmem_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .RESET(RESET),
    .core (core),
    .mem  (mem)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic        e_stall, e_merr, e_req, e_we;
  logic [31:0] e_rd, e_wdata;
  logic [29:0] e_addr;
  logic [31:0] model_rd;
  logic [31:0] mem_model [logic [29:0]];

  int          n_stall = 0, n_req = 0, n_merr = 0;
  logic [29:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  int          b_stall, b_req, b_merr;

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {2'b00, a} * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("STALL", 32'(core.STALL), 32'(e_stall));
      chk("MERR",  32'(core.MERR),  32'(e_merr));
      chk("RD",    core.RD,         e_rd);
      chk("m_req", 32'(mem.m_req),  32'(e_req));
      if (e_req) begin
        chk("m_we",   32'(mem.m_we),   32'(e_we));
        chk("m_addr", 32'(mem.m_addr), 32'(e_addr));
        if (e_we) chk("m_wdata", mem.m_wdata, e_wdata);
      end
      n_stall += 32'(core.STALL);
      n_req   += 32'(mem.m_req);
      n_merr  += 32'(core.MERR);
      if (mem.m_req) begin
        last_addr  = mem.m_addr;
        last_wdata = mem.m_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_stall = n_stall;
    b_req   = n_req;
    b_merr  = n_merr;
  endtask

  task automatic gap(input int n, input bit ack_hi = 1'b0);
    repeat (n) begin
      core.MOE    = 1'b0;
      core.MWR    = 1'b0;
      core.Adr    = $urandom;
      core.WD     = $urandom;
      mem.m_ack   = ack_hi ? 1'b1 : 1'($urandom_range(0, 1));
      mem.m_rdata = $urandom;
      e_stall = 1'b0; e_merr = 1'b0; e_req = 1'b0; e_rd = model_rd;
      step();
    end
  endtask

  // d = wait cycles before m_ack; d >= TO means the memory never answers
  task automatic txn(input bit moe, input bit mwr, input logic [31:0] adr,
                     input logic [31:0] wd, input int d);
    logic [29:0] wa;
    bit          err, tmo;
    int          nw;
    wa  = adr[31:2];
    err = (adr[1:0] != 2'b00) || (moe && mwr);
    core.MOE = moe; core.MWR = mwr; core.Adr = adr; core.WD = wd;
    mem.m_ack   = 1'($urandom_range(0, 1));
    mem.m_rdata = $urandom;
    e_stall = 1'b1; e_merr = 1'b0; e_req = 1'b0; e_rd = model_rd;
    step();
    if (err) begin
      if (moe) model_rd = '0;
      mem.m_ack = 1'($urandom_range(0, 1));
      e_stall = 1'b0; e_merr = 1'b1; e_req = 1'b0; e_rd = model_rd;
      step();
    end else begin
      tmo = (d >= TO);
      nw  = tmo ? TO : d + 1;
      for (int i = 0; i < nw; i++) begin
        mem.m_ack   = !tmo && (i == d);
        mem.m_rdata = (mem.m_ack && moe) ? mem_rd(wa) : $urandom;
        e_stall = 1'b1; e_merr = 1'b0; e_req = 1'b1; e_we = mwr;
        e_addr  = wa;   e_wdata = wd;  e_rd = model_rd;
        step();
      end
      if (moe) model_rd = tmo ? 32'h0 : mem_rd(wa);
      else if (!tmo) mem_model[wa] = wd;
      mem.m_ack   = 1'($urandom_range(0, 1));
      mem.m_rdata = $urandom;
      e_stall = 1'b0; e_merr = tmo; e_req = 1'b0; e_rd = model_rd;
      step();
    end
  endtask

  initial begin
    model_rd = '0;
    mem_model[30'h14] = 32'hA840_0800;
    RESET = 1'b1;
    core.MOE = 1'b1; core.MWR = 1'b0; core.Adr = 32'h50; core.WD = '0;
    mem.m_ack = 1'b0; mem.m_rdata = '0;
    #12;
    chk("reset STALL",   32'(core.STALL), 32'h0);
    chk("reset RD",      core.RD,         32'h0);
    chk("reset MERR",    32'(core.MERR),  32'h0);
    chk("reset m_req",   32'(mem.m_req),  32'h0);
    chk("reset m_we",    32'(mem.m_we),   32'h0);
    chk("reset m_addr",  32'(mem.m_addr), 32'h0);
    chk("reset m_wdata", mem.m_wdata,     32'h0);
    core.MOE = 1'b0;
    step();
    RESET = 1'b0;
    chk_en = 1'b1;
    gap(2);

    // misaligned load
    mark();
    txn(1'b1, 1'b0, 32'h52, 32'h0, 0);
    chk("misaligned stall cycles", 32'(n_stall - b_stall), 32'd1);
    chk("misaligned MERR pulses",  32'(n_merr - b_merr),   32'd1);
    chk("misaligned m_req cycles", 32'(n_req - b_req),     32'd0);
    chk("misaligned RD",           core.RD,                32'h0);
    gap(1);

    // aligned load, ack in third wait cycle
    mark();
    txn(1'b1, 1'b0, 32'h50, 32'h0, 2);
    chk("load m_addr",       32'(last_addr),         32'h14);
    chk("load RD",           core.RD,                32'hA840_0800);
    chk("load stall cycles", 32'(n_stall - b_stall), 32'd4);
    gap(1);

    // store, immediate ack
    mark();
    txn(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 0);
    chk("store m_addr",       32'(last_addr),         32'h40);
    chk("store m_wdata",      last_wdata,             32'hDEAD_BEEF);
    chk("store stall cycles", 32'(n_stall - b_stall), 32'd2);
    chk("store RD unchanged", core.RD,                32'hA840_0800);
    gap(1);

    // timeout then late acks
    mark();
    txn(1'b1, 1'b0, 32'h20, 32'h0, TO + 1);
    chk("timeout m_req cycles", 32'(n_req - b_req),   32'(TO));
    chk("timeout MERR pulses",  32'(n_merr - b_merr), 32'd1);
    chk("timeout RD",           core.RD,              32'h0);
    gap(3, 1'b1);

    // back-to-back LD, ST, then MOE&MWR
    mark();
    txn(1'b1, 1'b0, 32'h50, 32'h0, 1);
    txn(1'b0, 1'b1, 32'h54, 32'h0BAD_F00D, 0);
    chk("b2b stall cycles", 32'(n_stall - b_stall), 32'd5);
    chk("b2b RD",           core.RD,                32'hA840_0800);
    mark();
    txn(1'b1, 1'b1, 32'h58, 32'h0, 0);
    chk("moe&mwr m_req cycles", 32'(n_req - b_req),   32'd0);
    chk("moe&mwr MERR pulses",  32'(n_merr - b_merr), 32'd1);
    chk("moe&mwr RD",           core.RD,              32'h0);
    gap(1);

    // reset in the middle of a read wait
    txn(1'b1, 1'b0, 32'h50, 32'h0, 0);
    core.MOE = 1'b1; core.MWR = 1'b0; core.Adr = 32'h50; mem.m_ack = 1'b0;
    e_stall = 1'b1; e_merr = 1'b0; e_req = 1'b0; e_rd = model_rd;
    step();
    chk_en = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("mid-reset m_req", 32'(mem.m_req),  32'h0);
    chk("mid-reset STALL", 32'(core.STALL), 32'h0);
    chk("mid-reset RD",    core.RD,         32'h0);
    core.MOE = 1'b0;
    model_rd = '0;
    step();
    step();
    RESET = 1'b0;
    chk_en = 1'b1;
    gap(2);
    txn(1'b1, 1'b0, 32'h50, 32'h0, 0);
    chk("post-reset load RD", core.RD, 32'hA840_0800);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 31)) << 2;
      case (op)
        0:       txn(1'b1, 1'b1, a, $urandom, 0);
        1:       txn(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0, 0);
        2, 3, 4, 5: txn(1'b1, 1'b0, a, $urandom, $urandom_range(0, TO + 2));
        default: txn(1'b0, 1'b1, a, $urandom, $urandom_range(0, TO + 2));
      endcase
      gap($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
